// File: rtl/alu_exec_pkg.sv
// alu_exec_pkg: shared control encodings, FSM states and ALUOp codes for the execute stage.
package alu_exec_pkg;

    typedef enum logic [4:0] {
        CTRL_ADD    = 5'd0,
        CTRL_SUB    = 5'd1,
        CTRL_AND    = 5'd2,
        CTRL_OR     = 5'd3,
        CTRL_XOR    = 5'd4,
        CTRL_SLT    = 5'd5,
        CTRL_SLL    = 5'd6,
        CTRL_SRL    = 5'd7,
        CTRL_SRA    = 5'd8,
        CTRL_SLTU   = 5'd9,
        CTRL_MUL    = 5'd10,
        CTRL_MULH   = 5'd11,
        CTRL_MULHSU = 5'd12,
        CTRL_MULHU  = 5'd13,
        CTRL_DIV    = 5'd14,
        CTRL_DIVU   = 5'd15,
        CTRL_REM    = 5'd16,
        CTRL_REMU   = 5'd17
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        CALC = 2'd2
    } exec_state_e;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;

    function automatic logic is_muldiv(input alu_ctrl_e c);
        return c >= CTRL_MUL;
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: XLEN-step shift-add multiplier / restoring divider on magnitudes with sign fix-up.
module muldiv_iter
    import alu_exec_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  alu_ctrl_e       i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);

    localparam int CW = $clog2(XLEN);

    logic            r_run, r_negq, r_negr;
    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_hi, r_lo, r_m;
    alu_ctrl_e       r_op;

    logic            w_smul, w_mul, w_na, w_nb;
    logic [XLEN-1:0] w_ma, w_mb, w_nhi, w_nlo;
    logic [XLEN:0]   w_sum, w_shf, w_dif;
    logic [2*XLEN-1:0] w_p, w_pf;

    assign w_smul = i_op inside {CTRL_MUL, CTRL_MULH, CTRL_MULHSU, CTRL_MULHU};
    assign w_mul  = r_op inside {CTRL_MUL, CTRL_MULH, CTRL_MULHSU, CTRL_MULHU};
    assign w_na   = (i_op inside {CTRL_MULH, CTRL_MULHSU, CTRL_DIV, CTRL_REM}) & i_a[XLEN-1];
    assign w_nb   = (i_op inside {CTRL_MULH, CTRL_DIV, CTRL_REM}) & i_b[XLEN-1];
    assign w_ma   = w_na ? -i_a : i_a;
    assign w_mb   = w_nb ? -i_b : i_b;

    // hi:lo is product accumulator (multiplier in lo) or remainder:quotient (dividend in lo)
    assign w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);
    assign w_shf = {r_hi, r_lo[XLEN-1]};
    assign w_dif = w_shf - {1'b0, r_m};
    assign w_nhi = w_mul ? w_sum[XLEN:1] : (w_dif[XLEN] ? w_shf[XLEN-1:0] : w_dif[XLEN-1:0]);
    assign w_nlo = w_mul ? {w_sum[0], r_lo[XLEN-1:1]} : {r_lo[XLEN-2:0], ~w_dif[XLEN]};
    assign w_p   = {w_nhi, w_nlo};
    assign w_pf  = r_negq ? -w_p : w_p;

    assign o_done = r_run & (r_cnt == CW'(XLEN-1));

    always_comb begin
        o_result = w_pf[XLEN-1:0];
        case (r_op)
            CTRL_MULH, CTRL_MULHSU, CTRL_MULHU: o_result = w_pf[2*XLEN-1:XLEN];
            CTRL_DIV, CTRL_DIVU:                o_result = r_negq ? -w_nlo : w_nlo;
            CTRL_REM, CTRL_REMU:                o_result = r_negr ? -w_nhi : w_nhi;
            default:                            o_result = w_pf[XLEN-1:0];
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_run  <= 1'b0;
            r_cnt  <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_m    <= '0;
            r_op   <= CTRL_MUL;
            r_negq <= 1'b0;
            r_negr <= 1'b0;
        end else if (i_start) begin
            r_run  <= 1'b1;
            r_cnt  <= '0;
            r_hi   <= '0;
            r_lo   <= w_smul ? w_mb : w_ma;
            r_m    <= w_smul ? w_ma : w_mb;
            r_op   <= i_op;
            r_negq <= w_na ^ w_nb;
            r_negr <= w_na;
        end else if (r_run) begin
            r_hi  <= w_nhi;
            r_lo  <= w_nlo;
            r_cnt <= r_cnt + 1'b1;
            r_run <= !o_done;
        end
    end

endmodule

// File: rtl/alu_exec.sv
// alu_exec: RISC-V execute stage, decode + ALU with registered valid/ready output.
// Define ALU_EXEC_MULDIV_EN to build the iterative M-extension unit and CALC state.
module alu_exec
    import alu_exec_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [1:0]      i_aluop,
    input  logic [2:0]      i_funct3,
    input  logic            i_funct7b5,
    input  logic            i_funct7b0,
    input  logic            i_opb5,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result,
    output logic            o_zero,
    output logic            o_lt,
    output logic            o_ltu,
    output logic            o_illegal,
    output logic            o_busy
);

    localparam int SW = $clog2(XLEN);

    exec_state_e     r_state, w_state_n;
    logic [XLEN-1:0] r_result;
    logic            r_zero, r_lt, r_ltu, r_ill;

    alu_ctrl_e       w_ctrl;
    logic            w_ill, w_acc, w_md, w_done, w_lt, w_ltu, w_bz, w_ov;
    logic [XLEN-1:0] w_res, w_mdres;
    logic [SW-1:0]   w_sh;

    assign w_acc  = i_valid & o_ready;
    assign w_lt   = $signed(i_a) < $signed(i_b);
    assign w_ltu  = i_a < i_b;
    assign w_sh   = i_b[SW-1:0];
    assign w_bz   = i_b == '0;
    assign w_ov   = (i_a == {1'b1, {(XLEN-1){1'b0}}}) & (i_b == '1);

    assign o_valid   = r_state == HOLD;
    assign o_ready   = (r_state != CALC) & (!o_valid | i_ready);
    assign o_result  = r_result;
    assign o_zero    = r_zero;
    assign o_lt      = r_lt;
    assign o_ltu     = r_ltu;
    assign o_illegal = r_ill;

    always_comb begin
        w_ctrl = CTRL_ADD;
        w_ill  = 1'b0;
        if (i_aluop == ALUOP_BRANCH) begin
            w_ctrl = i_funct3[2] ? (i_funct3[1] ? CTRL_SLTU : CTRL_SLT) : CTRL_SUB;
            w_ill  = i_funct3[2:1] == 2'b01;
        end else if (i_aluop != ALUOP_ADD) begin
            if (i_opb5 & i_funct7b0) begin
`ifdef ALU_EXEC_MULDIV_EN
                w_ctrl = alu_ctrl_e'(5'(CTRL_MUL) + {2'b00, i_funct3});
`else
                w_ill  = 1'b1;
`endif
            end else begin
                case (i_funct3)
                    3'b000:  w_ctrl = (i_funct7b5 & i_opb5) ? CTRL_SUB : CTRL_ADD;
                    3'b001:  begin w_ctrl = CTRL_SLL; w_ill = i_funct7b5; end
                    3'b010:  w_ctrl = CTRL_SLT;
                    3'b011:  w_ctrl = CTRL_SLTU;
                    3'b100:  w_ctrl = CTRL_XOR;
                    3'b101:  w_ctrl = i_funct7b5 ? CTRL_SRA : CTRL_SRL;
                    3'b110:  w_ctrl = CTRL_OR;
                    default: w_ctrl = CTRL_AND;
                endcase
            end
        end
    end

    // divide special cases resolve here so they never enter CALC
    always_comb begin
        w_res = '0;
        case (w_ctrl)
            CTRL_ADD:  w_res = i_a + i_b;
            CTRL_SUB:  w_res = i_a - i_b;
            CTRL_AND:  w_res = i_a & i_b;
            CTRL_OR:   w_res = i_a | i_b;
            CTRL_XOR:  w_res = i_a ^ i_b;
            CTRL_SLT:  w_res = {{(XLEN-1){1'b0}}, w_lt};
            CTRL_SLTU: w_res = {{(XLEN-1){1'b0}}, w_ltu};
            CTRL_SLL:  w_res = i_a << w_sh;
            CTRL_SRL:  w_res = i_a >> w_sh;
            CTRL_SRA:  w_res = $signed(i_a) >>> w_sh;
            CTRL_DIV:  w_res = w_bz ? '1 : (w_ov ? i_a : '0);
            CTRL_DIVU: w_res = '1;
            CTRL_REM:  w_res = w_bz ? i_a : '0;
            CTRL_REMU: w_res = i_a;
            default:   w_res = '0;
        endcase
        if (w_ill) w_res = '0;
    end

`ifdef ALU_EXEC_MULDIV_EN
    assign w_md = is_muldiv(w_ctrl) & !w_ill
                & !(w_bz & (w_ctrl >= CTRL_DIV))
                & !(w_ov & (w_ctrl inside {CTRL_DIV, CTRL_REM}));
    assign o_busy = r_state == CALC;

    muldiv_iter #(.XLEN(XLEN)) u_muldiv (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_start  (w_acc & w_md),
        .i_op     (w_ctrl),
        .i_a      (i_a),
        .i_b      (i_b),
        .o_done   (w_done),
        .o_result (w_mdres)
    );
`else
    assign w_md    = 1'b0;
    assign w_done  = 1'b0;
    assign w_mdres = '0;
    assign o_busy  = 1'b0;
`endif

    always_comb begin
        w_state_n = r_state;
        if (r_state == CALC) w_state_n = w_done ? HOLD : CALC;
        else if (w_acc)      w_state_n = w_md ? CALC : HOLD;
        else if (i_ready)    w_state_n = IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_lt     <= 1'b0;
            r_ltu    <= 1'b0;
            r_ill    <= 1'b0;
        end else begin
            r_state <= w_state_n;
            if (w_acc) begin
                r_zero <= i_a == i_b;
                r_lt   <= w_lt;
                r_ltu  <= w_ltu;
                r_ill  <= w_ill;
                if (!w_md) r_result <= w_res;
            end
            if (w_done) r_result <= w_mdres;
        end
    end

endmodule
